// File: rtl/kitchen_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : kitchen_timer_ctrl
//  Description : Sequencing controller for the kitchen timer. Holds the mm:ss
//                setting as four BCD digits and runs the IDLE / RUN / PAUSE /
//                ALARM state machine, driven by a 1 Hz tick and one-cycle
//                button pulses.
//
//  Ports       : clk        system clock
//                rst        synchronous reset, active-high
//                tick       1 Hz one-cycle pulse from the timebase divider
//                btn_min    increment minutes (IDLE only)
//                btn_sec    increment seconds (IDLE only)
//                btn_start  start / pause toggle, acknowledges the alarm
//                btn_clear  zero the time and return to IDLE
//                min_t/min_o/sec_t/sec_o   BCD display digits
//                running    high in RUN
//                alarm      high in ALARM
//                state      IDLE=0, RUN=1, PAUSE=2, ALARM=3
//
//  Revision    : 1.0  initial release
// ============================================================================
module kitchen_timer_ctrl #(
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_min,
    input  logic       btn_sec,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic       running,
    output logic       alarm,
    output logic [1:0] state
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_PAUSE = 2'd2;
    localparam logic [1:0] c_ALARM = 2'd3;

    localparam logic [7:0] c_ALARM_LIM = 8'(ALARM_SECS);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [3:0] r_min_t, r_min_o, r_sec_t, r_sec_o;
    logic [1:0] r_state;
    logic [7:0] r_alarm_cnt;
    logic       r_running;
    logic       r_alarm;

    // ------------------------------------------------------------------------
    // Digit arithmetic helpers
    // ------------------------------------------------------------------------
    logic [3:0] w_min_inc_t, w_min_inc_o;
    logic [3:0] w_sec_inc_t, w_sec_inc_o;
    logic [3:0] w_dec_min_t, w_dec_min_o, w_dec_sec_t, w_dec_sec_o;
    logic       w_time_zero;
    logic       w_dec_zero;
    logic [7:0] w_cnt_inc;

    assign w_time_zero = (r_min_t == 4'd0) && (r_min_o == 4'd0) &&
                         (r_sec_t == 4'd0) && (r_sec_o == 4'd0);

    // Minutes count 00..99 and wrap.
    always_comb begin
        w_min_inc_t = r_min_t;
        w_min_inc_o = r_min_o + 4'd1;
        if (r_min_o == 4'd9) begin
            w_min_inc_o = 4'd0;
            w_min_inc_t = (r_min_t == 4'd9) ? 4'd0 : r_min_t + 4'd1;
        end
    end

    // Seconds count 00..59 and wrap without touching the minutes.
    always_comb begin
        w_sec_inc_t = r_sec_t;
        w_sec_inc_o = r_sec_o + 4'd1;
        if (r_sec_o == 4'd9) begin
            w_sec_inc_o = 4'd0;
            w_sec_inc_t = (r_sec_t == 4'd5) ? 4'd0 : r_sec_t + 4'd1;
        end
    end

    // One-second decrement with borrow chain. Only used while RUN, where the
    // time is never 00:00, so the minutes never underflow.
    always_comb begin
        w_dec_min_t = r_min_t;
        w_dec_min_o = r_min_o;
        w_dec_sec_t = r_sec_t;
        w_dec_sec_o = r_sec_o - 4'd1;
        if (r_sec_o == 4'd0) begin
            w_dec_sec_o = 4'd9;
            if (r_sec_t != 4'd0) begin
                w_dec_sec_t = r_sec_t - 4'd1;
            end else begin
                w_dec_sec_t = 4'd5;
                if (r_min_o != 4'd0) begin
                    w_dec_min_o = r_min_o - 4'd1;
                end else begin
                    w_dec_min_o = 4'd9;
                    w_dec_min_t = r_min_t - 4'd1;
                end
            end
        end
    end

    assign w_dec_zero = (w_dec_min_t == 4'd0) && (w_dec_min_o == 4'd0) &&
                        (w_dec_sec_t == 4'd0) && (w_dec_sec_o == 4'd0);

    assign w_cnt_inc = r_alarm_cnt + 8'd1;

    // ------------------------------------------------------------------------
    // Next-state logic. Event priority: clear > start > tick > min/sec; a
    // lower-priority pulse in the same cycle is simply dropped.
    // ------------------------------------------------------------------------
    logic [3:0] w_nxt_min_t, w_nxt_min_o, w_nxt_sec_t, w_nxt_sec_o;
    logic [1:0] w_nxt_state;
    logic [7:0] w_nxt_cnt;

    always_comb begin
        w_nxt_min_t = r_min_t;
        w_nxt_min_o = r_min_o;
        w_nxt_sec_t = r_sec_t;
        w_nxt_sec_o = r_sec_o;
        w_nxt_state = r_state;
        w_nxt_cnt   = r_alarm_cnt;

        if (btn_clear) begin
            w_nxt_min_t = 4'd0;
            w_nxt_min_o = 4'd0;
            w_nxt_sec_t = 4'd0;
            w_nxt_sec_o = 4'd0;
            w_nxt_state = c_IDLE;
            w_nxt_cnt   = 8'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (btn_start) begin
                        if (!w_time_zero) begin
                            w_nxt_state = c_RUN;
                        end
                    end else if (!tick) begin
                        if (btn_min) begin
                            w_nxt_min_t = w_min_inc_t;
                            w_nxt_min_o = w_min_inc_o;
                        end
                        if (btn_sec) begin
                            w_nxt_sec_t = w_sec_inc_t;
                            w_nxt_sec_o = w_sec_inc_o;
                        end
                    end
                end
                c_RUN: begin
                    if (btn_start) begin
                        w_nxt_state = c_PAUSE;
                    end else if (tick) begin
                        w_nxt_min_t = w_dec_min_t;
                        w_nxt_min_o = w_dec_min_o;
                        w_nxt_sec_t = w_dec_sec_t;
                        w_nxt_sec_o = w_dec_sec_o;
                        if (w_dec_zero) begin
                            w_nxt_state = c_ALARM;
                            w_nxt_cnt   = 8'd0;
                        end
                    end
                end
                c_PAUSE: begin
                    if (btn_start) begin
                        w_nxt_state = c_RUN;
                    end
                end
                default: begin  // c_ALARM
                    if (btn_start) begin
                        w_nxt_state = c_IDLE;
                        w_nxt_cnt   = 8'd0;
                    end else if (tick) begin
                        if (w_cnt_inc == c_ALARM_LIM) begin
                            w_nxt_state = c_IDLE;
                            w_nxt_cnt   = 8'd0;
                        end else begin
                            w_nxt_cnt = w_cnt_inc;
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers. running/alarm are decoded from the next
    // state so they change on the same edge as the state itself.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_min_t     <= 4'd0;
            r_min_o     <= 4'd0;
            r_sec_t     <= 4'd0;
            r_sec_o     <= 4'd0;
            r_state     <= c_IDLE;
            r_alarm_cnt <= 8'd0;
            r_running   <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            r_min_t     <= w_nxt_min_t;
            r_min_o     <= w_nxt_min_o;
            r_sec_t     <= w_nxt_sec_t;
            r_sec_o     <= w_nxt_sec_o;
            r_state     <= w_nxt_state;
            r_alarm_cnt <= w_nxt_cnt;
            r_running   <= (w_nxt_state == c_RUN);
            r_alarm     <= (w_nxt_state == c_ALARM);
        end
    end

    assign min_t   = r_min_t;
    assign min_o   = r_min_o;
    assign sec_t   = r_sec_t;
    assign sec_o   = r_sec_o;
    assign state   = r_state;
    assign running = r_running;
    assign alarm   = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_kitchen_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kitchen_timer_ctrl
//  Description : Self-checking bench for kitchen_timer_ctrl. A reference
//                model tracks minutes/seconds as integers and the mode as a
//                small number; a compare process checks every cycle, and
//                directed sequences add literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_kitchen_timer_ctrl;

    localparam int c_ALARM_SECS = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0, btn_min = 1'b0, btn_sec = 1'b0;
    logic       btn_start = 1'b0, btn_clear = 1'b0;
    logic [3:0] min_t, min_o, sec_t, sec_o;
    logic       running, alarm;
    logic [1:0] state;

    kitchen_timer_ctrl #(.ALARM_SECS(c_ALARM_SECS)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .btn_min(btn_min), .btn_sec(btn_sec),
        .btn_start(btn_start), .btn_clear(btn_clear),
        .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
        .running(running), .alarm(alarm), .state(state)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: time as integer minutes/seconds, mode as 0..3.
    // ------------------------------------------------------------------------
    int m_min = 0, m_sec = 0, m_mode = 0, m_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_min = 0; m_sec = 0; m_mode = 0; m_cnt = 0;
        end else if (btn_clear) begin
            m_min = 0; m_sec = 0; m_mode = 0; m_cnt = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (btn_start) begin
                        if (m_min * 60 + m_sec != 0) m_mode = 1;
                    end else if (!tick) begin
                        if (btn_min) m_min = (m_min + 1) % 100;
                        if (btn_sec) m_sec = (m_sec + 1) % 60;
                    end
                end
                1: begin
                    if (btn_start) m_mode = 2;
                    else if (tick) begin
                        int tot;
                        tot   = m_min * 60 + m_sec - 1;
                        m_min = tot / 60;
                        m_sec = tot % 60;
                        if (tot == 0) begin m_mode = 3; m_cnt = 0; end
                    end
                end
                2: if (btn_start) m_mode = 1;
                default: begin
                    if (btn_start) begin m_mode = 0; m_cnt = 0; end
                    else if (tick) begin
                        m_cnt++;
                        if (m_cnt == c_ALARM_SECS) begin m_mode = 0; m_cnt = 0; end
                    end
                end
            endcase
        end
    end

    function automatic int exp_digits();
        return ((m_min / 10) << 12) | ((m_min % 10) << 8) |
               ((m_sec / 10) << 4) | (m_sec % 10);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_digits", int'({min_t, min_o, sec_t, sec_o}), exp_digits());
            chk("cyc_state", int'(state), m_mode);
            chk("cyc_running", int'(running), int'(m_mode == 1));
            chk("cyc_alarm", int'(alarm), int'(m_mode == 3));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus: one cycle of inputs, driven at negedge and released after the
    // following posedge so outputs can be checked directly on return.
    // ------------------------------------------------------------------------
    task automatic cyc(input logic mn, input logic sc, input logic st,
                       input logic cl, input logic tk, input logic rs);
        @(negedge clk);
        btn_min = mn; btn_sec = sc; btn_start = st;
        btn_clear = cl; tick = tk; rst = rs;
        @(posedge clk);
        #1;
        btn_min = 0; btn_sec = 0; btn_start = 0;
        btn_clear = 0; tick = 0; rst = 0;
    endtask

    task automatic rep(input int n, input logic mn, input logic sc, input logic tk);
        for (int i = 0; i < n; i++) cyc(mn, sc, 1'b0, 1'b0, tk, 1'b0);
    endtask

    function automatic int digits();
        return int'({min_t, min_o, sec_t, sec_o});
    endfunction

    initial begin
        cyc(0, 0, 0, 0, 0, 1);
        chk_en = 1'b1;
        cyc(0, 0, 0, 0, 0, 1);
        chk("reset_digits", digits(), 'h0000);
        chk("reset_state", int'(state), 0);
        chk("reset_flags", int'({running, alarm}), 0);

        // Set 03:05, then a full lap of minutes.
        rep(3, 1, 0, 0);
        rep(5, 0, 1, 0);
        chk("set_0305", digits(), 'h0305);
        chk("set_state", int'(state), 0);
        rep(100, 1, 0, 0);
        chk("min_wrap", digits(), 'h0305);

        // Tick in IDLE is ignored; min+sec together both apply.
        cyc(0, 0, 0, 0, 1, 0);
        chk("idle_tick", digits(), 'h0305);
        cyc(1, 1, 0, 0, 0, 0);
        chk("min_sec_both", digits(), 'h0406);

        // 00:58 + 2 sec -> 00:00; start at zero ignored.
        cyc(0, 0, 0, 1, 0, 0);
        rep(58, 0, 1, 0);
        chk("set_0058", digits(), 'h0058);
        rep(2, 0, 1, 0);
        chk("sec_wrap", digits(), 'h0000);
        cyc(0, 0, 1, 0, 0, 0);
        chk("start_zero", int'(state), 0);

        // 01:00 countdown to alarm.
        rep(1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("run_state", int'(state), 1);
        rep(1, 0, 0, 1);
        chk("borrow_0059", digits(), 'h0059);
        chk("running", int'(running), 1);
        rep(58, 0, 0, 1);
        chk("at_0001", digits(), 'h0001);
        chk("at_0001_state", int'(state), 1);
        rep(1, 0, 0, 1);
        chk("alarm_digits", digits(), 'h0000);
        chk("alarm_state", int'(state), 3);
        chk("alarm_flag", int'(alarm), 1);

        // Alarm times out after ALARM_SECS ticks.
        rep(c_ALARM_SECS - 1, 0, 0, 1);
        chk("alarm_hold", int'(alarm), 1);
        rep(1, 0, 0, 1);
        chk("alarm_timeout", int'({state, alarm}), 0);

        // Alarm acknowledged by start after 2 ticks.
        rep(1, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        rep(1, 0, 0, 1);
        chk("alarm2_state", int'(state), 3);
        rep(2, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0);
        chk("alarm_ack", int'({state, alarm}), 0);

        // Start+tick in RUN -> PAUSE, tick dropped.
        rep(10, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        chk("pause_state", int'(state), 2);
        chk("pause_digits", digits(), 'h0010);
        rep(3, 0, 0, 1);
        chk("pause_hold", digits(), 'h0010);
        cyc(0, 0, 1, 0, 0, 0);
        chk("resume_state", int'(state), 1);
        rep(1, 0, 0, 1);
        chk("resume_tick", digits(), 'h0009);

        // Reset with coincident tick mid-countdown.
        rep(4, 0, 0, 1);
        chk("at_0005", digits(), 'h0005);
        cyc(0, 0, 0, 0, 1, 1);
        chk("rst_digits", digits(), 'h0000);
        chk("rst_state", int'({state, running}), 0);

        // Clear in PAUSE and clear in RUN.
        rep(2, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("pause2_state", int'(state), 2);
        cyc(0, 0, 0, 1, 0, 0);
        chk("clr_pause", int'({min_t, min_o, sec_t, sec_o, 2'(state)}), 0);
        rep(3, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("clr_run", int'({min_t, min_o, sec_t, sec_o, 2'(state)}), 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
